// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter: default widths,
// instruction opcode constants and the request record type.
package wb_pkg;

    localparam int WB_DATA_W    = 16;
    localparam int WB_REG_IDX_W = 4;
    localparam int WB_NUM_REGS  = 8;
    localparam int WB_NUM_REQ   = 3;

    // Opcode constants shared with the decode stage.
    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] MUL = 3'd2;
    localparam logic [2:0] LW  = 3'd3;
    localparam logic [2:0] SW  = 3'd4;
    localparam logic [2:0] BEQ = 3'd5;
    localparam logic [2:0] BNE = 3'd6;

    // One producer's pending write: destination index plus result.
    typedef struct packed {
        logic [WB_REG_IDX_W-1:0] reg_idx;
        logic [WB_DATA_W-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter. The scan starts at the pointer and
// wraps; after a grant the pointer moves just past the winner so the
// winner becomes lowest priority. No grant leaves the pointer unchanged.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N-1:0]         req_i,
    input  logic                 en_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 gnt_vld_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  gnt_s;
    logic [PW-1:0] gnt_idx_s;
    logic          found_s;

    // Scan requesters starting at the pointer, first valid one wins.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (en_i && !found_s && req_i[idx]) begin
                gnt_s[idx] = 1'b1;
                gnt_idx_s  = PW'(idx);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer: one past the winner with wrap, hold when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (found_s) begin
            if (gnt_idx_s == PW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o     = gnt_s;
    assign gnt_idx_o = gnt_idx_s;
    assign gnt_vld_o = found_s;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: round-robin among result producers,
// one write per cycle through a registered stage, with an index check.
// Optional feature macro: WB_BYPASS_EN adds a combinational forwarding
// copy (fwd_valid/fwd_reg/fwd_data) of the request accepted this cycle.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int REG_IDX_W = WB_REG_IDX_W,
    parameter int NUM_REGS  = WB_NUM_REGS,
    parameter int NUM_REQ   = WB_NUM_REQ
) (
    input  logic                           clkwire,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*REG_IDX_W-1:0]   req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           stall_wb,
    output logic                           writeToReg,
    output logic [REG_IDX_W-1:0]           regNos,
    output logic [DATA_W-1:0]              writeData,
    output logic                           err_idx
`ifdef WB_BYPASS_EN
    ,
    output logic                           fwd_valid,
    output logic [REG_IDX_W-1:0]           fwd_reg,
    output logic [DATA_W-1:0]              fwd_data
`endif
);

    logic [NUM_REQ-1:0]         gnt_s;
    logic [$clog2(NUM_REQ)-1:0] gnt_idx_s;
    logic                       xfer_s;
    logic                       arb_en_s;
    logic [REG_IDX_W-1:0]       sel_reg_s;
    logic [DATA_W-1:0]          sel_data_s;
    logic                       legal_s;

    logic                       wr_q,   wr_d;
    logic                       err_q,  err_d;
    logic [REG_IDX_W-1:0]       reg_q,  reg_d;
    logic [DATA_W-1:0]          data_q, data_d;

    // No grants while stalled or while reset is asserted.
    assign arb_en_s = ~stall_wb & rst_n;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i     (clkwire),
        .rst_n_i   (rst_n),
        .req_i     (req_valid),
        .en_i      (arb_en_s),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (xfer_s)
    );

    assign req_ready = gnt_s;

    // Select the granted producer's destination and data slices.
    always_comb begin
        sel_reg_s  = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_reg_s  = req_reg[i*REG_IDX_W +: REG_IDX_W];
                sel_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                sel_reg_s  = sel_reg_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    assign legal_s = (int'(sel_reg_s) < NUM_REGS);

    // Next output-stage contents; illegal indices are consumed but flagged.
    always_comb begin
        wr_d   = 1'b0;
        err_d  = 1'b0;
        reg_d  = reg_q;
        data_d = data_q;
        if (xfer_s) begin
            if (legal_s) begin
                wr_d   = 1'b1;
                reg_d  = sel_reg_s;
                data_d = sel_data_s;
            end else begin
                err_d  = 1'b1;
            end
        end else begin
            wr_d  = 1'b0;
            err_d = 1'b0;
        end
    end

    // Registered write-back stage; reset discards any in-flight write.
    always_ff @(posedge clkwire or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            err_q  <= err_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign writeToReg = wr_q;
    assign err_idx    = err_q;
    assign regNos     = reg_q;
    assign writeData  = data_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid = xfer_s & legal_s;
    assign fwd_reg   = sel_reg_s;
    assign fwd_data  = sel_data_s;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run compared against a behavioural round-robin model.
module tb_wb_port_arbiter;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int NR = 8;
    localparam int NQ = 3;

    logic             clkwire = 1'b0;
    logic             rst_n;
    logic [NQ-1:0]    req_valid;
    logic [NQ*RW-1:0] req_reg;
    logic [NQ*DW-1:0] req_data;
    logic [NQ-1:0]    req_ready;
    logic             stall_wb;
    logic             writeToReg;
    logic [RW-1:0]    regNos;
    logic [DW-1:0]    writeData;
    logic             err_idx;
`ifdef WB_BYPASS_EN
    logic             fwd_valid;
    logic [RW-1:0]    fwd_reg;
    logic [DW-1:0]    fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr;
    logic          m_wtr;
    logic [RW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic          m_err;

    always #5 clkwire = ~clkwire;

    wb_port_arbiter dut (
        .clkwire    (clkwire),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .stall_wb   (stall_wb),
        .writeToReg (writeToReg),
        .regNos     (regNos),
        .writeData  (writeData),
        .err_idx    (err_idx)
`ifdef WB_BYPASS_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_reg    (fwd_reg),
        .fwd_data   (fwd_data)
`endif
    );

    // Round-robin rule: first valid requester from the pointer, modulo NQ.
    function automatic logic [NQ-1:0] f_grant(input logic [NQ-1:0] v, input int p, input logic s);
        logic [NQ-1:0] r;
        r = '0;
        if (!s) begin
            for (int k = 0; k < NQ; k++) begin
                int i;
                i = (p + k) % NQ;
                if (v[i] && r == '0) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_wtr = 1'b0; m_reg = '0; m_data = '0; m_err = 1'b0;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic [NQ-1:0] g;
        g = f_grant(req_valid, m_ptr, stall_wb);
        @(posedge clkwire);
        m_wtr = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            if (g[i]) begin
                if (int'(req_reg[i*RW +: RW]) < NR) begin
                    m_wtr  = 1'b1;
                    m_reg  = req_reg[i*RW +: RW];
                    m_data = req_data[i*DW +: DW];
                end else begin
                    m_err = 1'b1;
                end
                m_ptr = (i + 1) % NQ;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_wb = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
        repeat (2) @(posedge clkwire);
        #1;
        model_reset();
        req_valid = 3'b001;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        checks++; if (writeToReg !== 1'b0) begin errors++; $display("FAIL reset_wtr: got %b want 0", writeToReg); end
        checks++; if (regNos !== 4'd0) begin errors++; $display("FAIL reset_reg: got %0h want 0", regNos); end
        checks++; if (writeData !== 16'h0000) begin errors++; $display("FAIL reset_data: got %0h want 0", writeData); end
        checks++; if (err_idx !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_idx); end
        req_valid = '0;
        rst_n = 1'b1;
        // transfer in flight, then reset mid-cycle with ALU still valid
        req_reg[3:0] = 4'd7; req_data[15:0] = 16'h1234; req_valid = 3'b001;
        tick();
        checks++; if (writeToReg !== 1'b1) begin errors++; $display("FAIL inflight_wtr: got %b want 1", writeToReg); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (writeToReg !== 1'b0) begin errors++; $display("FAIL midrst_wtr: got %b want 0", writeToReg); end
        checks++; if (regNos !== 4'd0) begin errors++; $display("FAIL midrst_reg: got %0h want 0", regNos); end
        checks++; if (writeData !== 16'h0000) begin errors++; $display("FAIL midrst_data: got %0h want 0", writeData); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL midrst_ready: got %b want 000", req_ready); end
        req_valid = '0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_reg[3:0] = 4'd3; req_data[15:0] = 16'h00AB; req_valid = 3'b001;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b want 001", req_ready); end
`ifdef WB_BYPASS_EN
        checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 4'd3 || fwd_data !== 16'h00AB) begin errors++; $display("FAIL single_fwd: got %b/%0h/%0h want 1/3/ab", fwd_valid, fwd_reg, fwd_data); end
`endif
        tick();
        req_valid = '0;
        checks++; if (writeToReg !== 1'b1) begin errors++; $display("FAIL single_wtr: got %b want 1", writeToReg); end
        checks++; if (regNos !== 4'd3) begin errors++; $display("FAIL single_reg: got %0h want 3", regNos); end
        checks++; if (writeData !== 16'h00AB) begin errors++; $display("FAIL single_data: got %0h want ab", writeData); end
        tick();
        checks++; if (writeToReg !== 1'b0 || regNos !== 4'd3) begin errors++; $display("FAIL single_idle: got %b/%0h want 0/3", writeToReg, regNos); end
    endtask

    task automatic test_contention();
        logic [NQ-1:0] exp_g [3];
        logic [RW-1:0] exp_r [3];
        logic [DW-1:0] exp_d [3];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_r[0] = 4'd1;   exp_r[1] = 4'd2;   exp_r[2] = 4'd5;
        exp_d[0] = 16'd10; exp_d[1] = 16'd20; exp_d[2] = 16'd30;
        do_reset();
        for (int i = 0; i < NQ; i++) begin
            req_reg[i*RW +: RW]  = exp_r[i];
            req_data[i*DW +: DW] = exp_d[i];
        end
        req_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== exp_g[k]) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", k, req_ready, exp_g[k]); end
            tick();
            req_valid = req_valid & ~exp_g[k];
            checks++; if (writeToReg !== 1'b1 || regNos !== exp_r[k] || writeData !== exp_d[k]) begin
                errors++; $display("FAIL cont_write%0d: got %b/%0h/%0h want 1/%0h/%0h", k, writeToReg, regNos, writeData, exp_r[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_wrap();
        req_reg[4 +: 4] = 4'd6; req_data[16 +: 16] = 16'd7; req_valid = 3'b010;
        tick();   // MUL alone: pointer now 2
        req_reg[0 +: 4] = 4'd4; req_data[0 +: 16] = 16'h0044;
        req_reg[8 +: 4] = 4'd7; req_data[32 +: 16] = 16'h0077;
        req_valid = 3'b101;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL wrap_lsu: got %b want 100", req_ready); end
        tick();
        checks++; if (regNos !== 4'd7 || writeData !== 16'h0077) begin errors++; $display("FAIL wrap_lsu_wr: got %0h/%0h want 7/77", regNos, writeData); end
        req_valid = 3'b001;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL wrap_alu: got %b want 001", req_ready); end
        tick();
        checks++; if (regNos !== 4'd4 || writeData !== 16'h0044) begin errors++; $display("FAIL wrap_alu_wr: got %0h/%0h want 4/44", regNos, writeData); end
        req_valid = 3'b111;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL wrap_ptr1: got %b want 010", req_ready); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_illegal();
        req_reg[4 +: 4] = 4'd9; req_data[16 +: 16] = 16'hFFFF; req_valid = 3'b010;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL ill_ready: got %b want 010", req_ready); end
`ifdef WB_BYPASS_EN
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL ill_fwd: got %b want 0", fwd_valid); end
`endif
        tick();
        req_valid = '0;
        checks++; if (writeToReg !== 1'b0 || err_idx !== 1'b1) begin errors++; $display("FAIL ill_flag: got wtr %b err %b want 0 1", writeToReg, err_idx); end
        checks++; if (regNos !== 4'd4 || writeData !== 16'h0044) begin errors++; $display("FAIL ill_hold: got %0h/%0h want 4/44", regNos, writeData); end
        tick();
        checks++; if (err_idx !== 1'b0) begin errors++; $display("FAIL ill_pulse: got %b want 0", err_idx); end
    endtask

    task automatic test_stall();
        // pointer is 2: ALU outranks MUL only if the pointer stays frozen
        req_reg[0 +: 4] = 4'd2; req_data[0 +: 16] = 16'h5A5A;
        req_reg[4 +: 4] = 4'd1; req_data[16 +: 16] = 16'h0101;
        req_valid = 3'b011; stall_wb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready%0d: got %b want 000", k, req_ready); end
`ifdef WB_BYPASS_EN
            checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL stall_fwd%0d: got %b want 0", k, fwd_valid); end
`endif
            tick();
            checks++; if (writeToReg !== 1'b0) begin errors++; $display("FAIL stall_wtr%0d: got %b want 0", k, writeToReg); end
        end
        stall_wb = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL stall_release: got %b want 001", req_ready); end
`ifdef WB_BYPASS_EN
        checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL stall_fwd_grant: got %b want 1", fwd_valid); end
`endif
        tick();
        req_valid = 3'b010;
        checks++; if (writeToReg !== 1'b1 || regNos !== 4'd2 || writeData !== 16'h5A5A) begin errors++; $display("FAIL stall_write: got %b/%0h/%0h want 1/2/5a5a", writeToReg, regNos, writeData); end
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL stall_next: got %b want 010", req_ready); end
        tick();
        req_valid = '0;
        #1;
`ifdef WB_BYPASS_EN
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL stall_fwd_after: got %b want 0", fwd_valid); end
`endif
    endtask

    task automatic test_random();
        int            wait_cnt [NQ];
        logic [NQ-1:0] g;
        for (int i = 0; i < NQ; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i]         = 1'b1;
                    req_reg[i*RW +: RW]  = RW'($urandom_range(0, 10));
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            stall_wb = ($urandom_range(0, 4) == 0);
            #1;
            g = f_grant(req_valid, m_ptr, stall_wb);
            checks++; if (req_ready !== g) begin errors++; $display("FAIL rnd_grant c%0d: got %b want %b", n, req_ready, g); end
`ifdef WB_BYPASS_EN
            checks++; if (fwd_valid !== (g != '0 && int'(req_reg[m_ptr_dummy(g)*RW +: RW]) < NR)) begin errors++; $display("FAIL rnd_fwd c%0d: got %b", n, fwd_valid); end
`endif
            for (int i = 0; i < NQ; i++) begin
                if (req_valid[i] && !stall_wb && !g[i]) begin
                    wait_cnt[i]++;
                    checks++; if (wait_cnt[i] > NQ - 1) begin errors++; $display("FAIL rnd_fair req%0d: waited %0d want <= %0d", i, wait_cnt[i], NQ - 1); end
                end
            end
            tick();
            for (int i = 0; i < NQ; i++) if (g[i]) wait_cnt[i] = 0;
            req_valid = req_valid & ~g;
            checks++; if (writeToReg !== m_wtr || err_idx !== m_err || regNos !== m_reg || writeData !== m_data) begin
                errors++; $display("FAIL rnd_out c%0d: got %b/%b/%0h/%0h want %b/%b/%0h/%0h", n, writeToReg, err_idx, regNos, writeData, m_wtr, m_err, m_reg, m_data);
            end
        end
        req_valid = '0; stall_wb = 1'b0;
    endtask

    // Index of the single set bit of a one-hot grant (0 when none).
    function automatic int m_ptr_dummy(input logic [NQ-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < NQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_illegal();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
